// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the ccff chain loader: FSM states, CRC
// parameters and the counter-width helper.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        VERIFY,
        DONE
    } ld_state_e;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // Width of a counter that must be able to hold the value n itself.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Host configuration-word stream (valid/ready) feeding the ccff chain loader.
interface ccff_chain_loader_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;

    modport master (output cfg_data, output cfg_valid, input cfg_ready);
    modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/ccff_crc16.sv
// Bit-serial CRC-16-CCITT (MSB-first shift), synchronous clear, bit enable.
module ccff_crc16
    import ccff_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    logic fb;
    assign fb = crc[15] ^ din;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            crc <= CRC_INIT;
        else if (clr)
            crc <= CRC_INIT;
        else if (en)
            crc <= {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// Serialises host configuration words into a tile's ccff chain, one bit per
// prog_clk. Define CCFF_READBACK_EN to add a recirculating CRC readback check.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 42,
    parameter int WORD_W    = 32
) (
    input  logic                prog_clk,
    input  logic                pReset_n,
    input  logic                start,
    ccff_chain_loader_if.slave  cfg,
    output logic                ccff_head,
    input  logic                ccff_tail,
    output logic                chain_shift_en,
    output logic                busy,
    output logic                done,
    output logic                cfg_error
);

    localparam int BW = cnt_w(CHAIN_LEN);
    localparam int WW = cnt_w(WORD_W);
    localparam logic [BW-1:0] LAST    = BW'(CHAIN_LEN);
    localparam logic [BW-1:0] LAST_M1 = BW'(CHAIN_LEN - 1);

    ld_state_e         state, state_nxt;
    logic [WORD_W-1:0] sbuf;
    logic [WW-1:0]     buf_cnt;
    logic [WW-1:0]     take;
    logic [BW-1:0]     bit_cnt;
    logic [BW-1:0]     acc_cnt;
    logic              head_q;
    logic              shifting;
    logic              last_shift;
    logic              accept;
    logic              kick;
    int                rem;

    assign kick       = (state == IDLE) && start;
    assign shifting   = (state == LOAD) && (buf_cnt != '0);
    assign last_shift = shifting && (bit_cnt == LAST_M1);

    // Refill when empty, or one bit early so the next word lands with no bubble.
    assign cfg.cfg_ready = (state == LOAD) && (acc_cnt != LAST) &&
                           ((buf_cnt == WW'(0)) || (buf_cnt == WW'(1)));
    assign accept        = cfg.cfg_ready && cfg.cfg_valid;

    always_comb begin
        rem  = CHAIN_LEN - int'(acc_cnt);
        take = (rem < WORD_W) ? WW'(rem) : WW'(WORD_W);
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            sbuf    <= '0;
            buf_cnt <= '0;
            bit_cnt <= '0;
            acc_cnt <= '0;
            head_q  <= 1'b0;
        end else begin
            if (kick) begin
                bit_cnt <= '0;
                acc_cnt <= '0;
                buf_cnt <= '0;
            end
            if (accept) begin
                sbuf    <= cfg.cfg_data;
                buf_cnt <= take;
                acc_cnt <= acc_cnt + BW'(take);
            end else if (shifting) begin
                sbuf    <= sbuf >> 1;
                buf_cnt <= buf_cnt - 1'b1;
            end
            if (shifting) begin
                head_q <= sbuf[0];
                if (bit_cnt != LAST)
                    bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

`ifdef CCFF_READBACK_EN
    logic [BW-1:0] ver_cnt;
    logic [15:0]   crc_ld;
    logic [15:0]   crc_rb;
    logic          err_q;
    logic          ver_last;

    assign ver_last = (state == VERIFY) && (ver_cnt == LAST_M1);

    ccff_crc16 u_crc_ld (
        .clk   (prog_clk),
        .rst_n (pReset_n),
        .clr   (kick),
        .en    (shifting),
        .din   (sbuf[0]),
        .crc   (crc_ld)
    );

    ccff_crc16 u_crc_rb (
        .clk   (prog_clk),
        .rst_n (pReset_n),
        .clr   (kick),
        .en    (state == VERIFY),
        .din   (ccff_tail),
        .crc   (crc_rb)
    );

    // Both CRCs are final once DONE is reached; error stays up until next start.
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            ver_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (kick)
                err_q <= 1'b0;
            else if (state == DONE)
                err_q <= (crc_ld != crc_rb);
            if (last_shift)
                ver_cnt <= '0;
            else if (state == VERIFY)
                ver_cnt <= ver_cnt + 1'b1;
        end
    end

    assign cfg_error = err_q;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign cfg_error   = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = LOAD;
            LOAD: if (last_shift) begin
`ifdef CCFF_READBACK_EN
                state_nxt = VERIFY;
`else
                state_nxt = DONE;
`endif
            end
`ifdef CCFF_READBACK_EN
            VERIFY: if (ver_last) state_nxt = DONE;
`endif
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stalls hold the last driven bit so the chain input never glitches.
    always_comb begin
        ccff_head      = shifting ? sbuf[0] : head_q;
        chain_shift_en = shifting;
`ifdef CCFF_READBACK_EN
        if (state == VERIFY) begin
            ccff_head      = ccff_tail;
            chain_shift_en = 1'b1;
        end
`endif
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule
